// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter: sprite OAM DMA sequencer sitting between the 6502 core
// wrapper and the system bus. A CPU write to $4014 latches a source page.
// The block then halts the CPU through RDY, copies {page,$00..$FF} to
// $2004 and returns the bus. Outside DMA the CPU bus passes straight through.
//
// Ports:
//   clk, rst          clock (one CPU cycle per edge), async active-low reset
//   cpu_addr/_data_out/_ren/_wen   CPU bus request (inputs)
//   cpu_data_in       read data to CPU (mirrors bus_data_in)
//   cpu_rdy           RDY to core: ext_rdy gated off while DMA owns the bus
//   ext_rdy           external RDY from the rest of the system
//   bus_addr/_data_out/_ren/_wen   system bus request (combinational)
//   bus_data_in       system bus read data
//   dma_busy          high whenever the sequencer is not idle
module oam_dma_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_ren,
  input  logic        cpu_wen,
  output logic [7:0]  cpu_data_in,
  output logic        cpu_rdy,
  input  logic        ext_rdy,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_data_out,
  output logic        bus_ren,
  output logic        bus_wen,
  input  logic [7:0]  bus_data_in,
  output logic        dma_busy
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  localparam logic [ADDR_W-1:0] DMA_REG_ADDR  = 16'h4014;
  localparam logic [ADDR_W-1:0] OAM_DATA_ADDR = 16'h2004;
  localparam logic [DATA_W-1:0] LAST_IDX      = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   page_q,  page_d;
  logic [DATA_W-1:0]   idx_q,   idx_d;
  logic [DATA_W-1:0]   latch_q, latch_d;
  logic                cyc_odd_q, cyc_odd_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      page_q    <= '0;
      idx_q     <= '0;
      latch_q   <= '0;
      cyc_odd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      page_q    <= page_d;
      idx_q     <= idx_d;
      latch_q   <= latch_d;
      cyc_odd_q <= cyc_odd_d;
    end
  end

  // Next-state logic and bus steering; default is CPU pass-through
  always_comb begin
    state_d      = state_q;
    page_d       = page_q;
    idx_d        = idx_q;
    latch_d      = latch_q;
    cyc_odd_d    = ~cyc_odd_q;
    bus_addr     = cpu_addr;
    bus_data_out = cpu_data_out;
    bus_ren      = cpu_ren;
    bus_wen      = cpu_wen;

    case (state_q)
      S_IDLE: begin
        if (cpu_wen && (cpu_addr == DMA_REG_ADDR)) begin
          page_d  = cpu_data_out;
          state_d = S_HALT;
        end
      end

      // CPU keeps the bus until it issues a read; that read is the halt cycle.
      // Reads must land on even cycles, so peek at the next cycle's parity.
      S_HALT: begin
        if (cpu_ren) begin
          state_d = cyc_odd_d ? S_ALIGN : S_READ;
        end
      end

      S_ALIGN: begin
        bus_ren = 1'b0;
        bus_wen = 1'b0;
        state_d = S_READ;
      end

      S_READ: begin
        bus_addr = {page_q, idx_q};
        bus_ren  = 1'b1;
        bus_wen  = 1'b0;
        latch_d  = bus_data_in;
        state_d  = S_WRITE;
      end

      S_WRITE: begin
        bus_addr     = OAM_DATA_ADDR;
        bus_data_out = latch_q;
        bus_ren      = 1'b0;
        bus_wen      = 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          idx_d   = DATA_W'(idx_q + 8'd1);
          state_d = S_READ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cpu_data_in = bus_data_in;
  assign dma_busy    = (state_q != S_IDLE);
  assign cpu_rdy     = ext_rdy & ~dma_busy;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// tb_oam_dma_arbiter: directed bench for oam_dma_arbiter. A small RAM model
// answers bus reads; each DMA is walked cycle by cycle and every OAM write,
// every DMA read, the halt length and the pass-through behaviour are checked.
module tb_oam_dma_arbiter;

  logic        clk;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_ren;
  logic        cpu_wen;
  logic [7:0]  cpu_data_in;
  logic        cpu_rdy;
  logic        ext_rdy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data_out;
  logic        bus_ren;
  logic        bus_wen;
  logic [7:0]  bus_data_in;
  logic        dma_busy;

  logic        tb_odd;
  int          n_vec;
  int          n_err;

  oam_dma_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_addr     (cpu_addr),
    .cpu_data_out (cpu_data_out),
    .cpu_ren      (cpu_ren),
    .cpu_wen      (cpu_wen),
    .cpu_data_in  (cpu_data_in),
    .cpu_rdy      (cpu_rdy),
    .ext_rdy      (ext_rdy),
    .bus_addr     (bus_addr),
    .bus_data_out (bus_data_out),
    .bus_ren      (bus_ren),
    .bus_wen      (bus_wen),
    .bus_data_in  (bus_data_in),
    .dma_busy     (dma_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle parity: cleared by reset, toggles on every edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) tb_odd <= 1'b0;
    else      tb_odd <= ~tb_odd;
  end

  // RAM contents: page $02 holds i^$A5, other pages hold i^$5A^page.
  function automatic logic [7:0] ram_rd(input logic [15:0] a);
    if (a[15:8] == 8'h02) return a[7:0] ^ 8'hA5;
    return a[7:0] ^ 8'h5A ^ a[15:8];
  endfunction

  assign bus_data_in = ram_rd(bus_addr);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic r, input logic w);
    cpu_addr     = a;
    cpu_data_out = d;
    cpu_ren      = r;
    cpu_wen      = w;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Trigger a DMA from page pg at the given cycle parity, optionally with
  // CPU write stalls, a reset after abort_at bytes, or ext_rdy dropped.
  task automatic do_dma(input logic [7:0] pg, input logic trig_odd, input int stall,
                        input int abort_at, input bit ext_drop);
    int   nw, nr, nbusy, nlow, nquiet, k, want;
    logic halt_odd;
    logic [15:0] sa;
    logic [7:0]  sd;
    bit   aborted, done;
    nw = 0; nr = 0; nbusy = 0; nlow = 0; nquiet = 0;
    aborted = 0; done = 0;
    for (int g = 0; g < 4 && tb_odd !== trig_odd; g++) tick();
    halt_odd = trig_odd ^ ((stall % 2) == 0);
    want = stall + 1 + (halt_odd ? 0 : 1) + 512;

    drive(16'h4014, pg, 1'b0, 1'b1);
    @(negedge clk);
    check_val("trig_strobes", 32'({bus_wen, bus_ren, dma_busy}), 32'(3'b100));
    check_val("trig_addr", 32'(bus_addr), 32'h4014);
    tick();

    for (k = 0; k < 800; k++) begin
      if (k < stall) begin
        sa = (k == 0) ? 16'h4014 : 16'(16'h01F0 + k);
        sd = 8'(8'h07 + k);
        drive(sa, sd, 1'b0, 1'b1);
      end else begin
        drive(16'h8123, 8'h00, 1'b1, 1'b0);
      end
      @(negedge clk);
      if (!dma_busy) begin
        done = 1;
        break;
      end
      nbusy++;
      if (!cpu_rdy) nlow++;
      if (k < stall) begin
        check_val("stall_wr", 32'({bus_wen, bus_ren, bus_addr, bus_data_out}),
                  32'({1'b1, 1'b0, sa, sd}));
      end else if (bus_wen) begin
        check_val("wr_addr", 32'(bus_addr), 32'h2004);
        check_val("wr_data", 32'(bus_data_out), 32'(ram_rd({pg, 8'(nw)})));
        check_val("wr_odd", 32'(tb_odd), 32'd1);
        nw++;
      end else if (bus_ren && bus_addr != 16'h8123) begin
        check_val("rd_addr", 32'(bus_addr), 32'({pg, 8'(nr)}));
        check_val("rd_odd", 32'(tb_odd), 32'd0);
        nr++;
      end else if (!bus_ren) begin
        nquiet++;
      end
      if (ext_drop && nw == 100) ext_rdy = 1'b0;
      if (abort_at >= 0 && nw == abort_at) begin
        rst = 1'b0;
        #1;
        check_val("rst_busy", 32'(dma_busy), 32'd0);
        check_val("rst_rdy", 32'(cpu_rdy), 32'd1);
        check_val("rst_pass", 32'({bus_ren, bus_wen, bus_addr}), 32'({1'b1, 1'b0, 16'h8123}));
        @(posedge clk);
        #1 rst = 1'b1;
        aborted = 1;
        break;
      end
      tick();
    end

    if (!aborted) begin
      check_val("no_timeout", 32'(done), 32'd1);
      check_val("busy_len", 32'(nbusy), 32'(want));
      check_val("rdy_low", 32'(nlow), 32'(want));
      check_val("n_writes", 32'(nw), 32'd256);
      check_val("n_reads", 32'(nr), 32'd256);
      check_val("align_cyc", 32'(nquiet), halt_odd ? 32'd0 : 32'd1);
      check_val("idle_pass", 32'({bus_ren, bus_wen, bus_addr}), 32'({1'b1, 1'b0, 16'h8123}));
      check_val("rdy_after", 32'(cpu_rdy), ext_drop ? 32'd0 : 32'd1);
      if (ext_drop) begin
        ext_rdy = 1'b1;
        #1;
        check_val("rdy_restore", 32'(cpu_rdy), 32'd1);
      end
      tick();
    end
    drive(16'h0000, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b0;
    ext_rdy = 1'b1;
    drive(16'h1234, 8'h9A, 1'b1, 1'b0);
    #2;
    check_val("rst_busy0", 32'(dma_busy), 32'd0);
    check_val("rst_rdy0", 32'(cpu_rdy), 32'd1);
    check_val("rst_bus0", 32'({bus_ren, bus_wen, bus_addr, bus_data_out}),
              32'({1'b1, 1'b0, 16'h1234, 8'h9A}));
    ext_rdy = 1'b0;
    #1;
    check_val("rst_rdy_ext", 32'(cpu_rdy), 32'd0);
    ext_rdy = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    // Pass-through write then read
    drive(16'h0300, 8'h55, 1'b0, 1'b1);
    @(negedge clk);
    check_val("pt_wr", 32'({bus_wen, bus_ren, bus_addr, bus_data_out}),
              32'({1'b1, 1'b0, 16'h0300, 8'h55}));
    check_val("pt_wr_rdy", 32'({cpu_rdy, dma_busy}), 32'(2'b10));
    tick();
    drive(16'h8000, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    check_val("pt_rd", 32'({bus_wen, bus_ren, bus_addr}), 32'({1'b0, 1'b1, 16'h8000}));
    check_val("pt_rd_data", 32'(cpu_data_in), 32'(8'h80 ^ 8'h5A ^ 8'h00));
    check_val("pt_rd_rdy", 32'({cpu_rdy, dma_busy}), 32'(2'b10));
    tick();
    drive(16'h0000, 8'h00, 1'b0, 1'b0);

    do_dma(8'h02, 1'b0, 0, -1, 1'b0);   // basic, no align: 513 cycles
    do_dma(8'h02, 1'b1, 0, -1, 1'b0);   // align: 514 cycles
    do_dma(8'h02, 1'b0, 2, -1, 1'b0);   // two stall writes, first to $4014 ignored
    do_dma(8'h02, 1'b0, 0, 100, 1'b0);  // reset after 100 bytes
    do_dma(8'h03, 1'b0, 0, -1, 1'b0);   // fresh full transfer of page $03
    do_dma(8'h03, 1'b1, 0, -1, 1'b1);   // ext_rdy dropped mid-transfer

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
